inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/inst_fetch_unit_if.sv | 37 +++
 rtl/fetch_queue.sv | 95 +++++++++
 rtl/inst_fetch_unit.sv | 101 ++++++++++
 tb/tb_inst_fetch_unit.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and the instruction-queue entry type for the fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned INST_BYTES = 4;

    // Last word-aligned address; a fetch pair starting here would wrap
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = 8'hFC;

    // One queued instruction together with the byte address it came from
    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [ADDR_W-1:0] pc;
    } fq_entry_t;

endpackage : riscv_pkg

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, redirect request and issue port.
//   slave  : seen by inst_fetch_unit (drives inst_address and issue_*)
//   master : seen by the environment (memory, branch unit, decode)
interface inst_fetch_unit_if;
    import riscv_pkg::*;

    logic                   fetch_en;
    logic [ADDR_W-1:0]      inst_address;
    logic [XLEN-1:0]        instruction1;
    logic [XLEN-1:0]        instruction2;
    logic                   redirect_valid;
    logic [ADDR_W-1:0]      redirect_pc;
    logic                   issue_valid0;
    logic                   issue_valid1;
    logic [XLEN-1:0]        issue_inst0;
    logic [XLEN-1:0]        issue_inst1;
    logic [ADDR_W-1:0]      issue_pc0;
    logic [ADDR_W-1:0]      issue_pc1;
    logic [1:0]             issue_take;

    modport slave (
        input  fetch_en, instruction1, instruction2,
        input  redirect_valid, redirect_pc, issue_take,
        output inst_address,
        output issue_valid0, issue_valid1, issue_inst0, issue_inst1,
        output issue_pc0, issue_pc1
    );

    modport master (
        output fetch_en, instruction1, instruction2,
        output redirect_valid, redirect_pc, issue_take,
        input  inst_address,
        input  issue_valid0, issue_valid1, issue_inst0, issue_inst1,
        input  issue_pc0, issue_pc1
    );

endinterface : inst_fetch_unit_if

// File: rtl/fetch_queue.sv
// Circular instruction queue: push 0/1/2, pop 0/1/2 in the same cycle, flush.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_flush              empty the queue (wins over push/pop)
//   i_push_cnt, i_push0/1 entries to append (caller keeps push <= free)
//   i_pop_cnt            entries consumed (caller keeps pop <= count)
//   o_count              registered occupancy 0..QDEPTH
//   o_valid0/1, o_head0/1 head and head+1 entries, zeroed when absent
module fetch_queue
    import riscv_pkg::*;
#(
    parameter  int unsigned QDEPTH = 4,
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1),
    localparam int unsigned PTR_W  = $clog2(QDEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [1:0]       i_push_cnt,
    input  fq_entry_t        i_push0,
    input  fq_entry_t        i_push1,
    input  logic [1:0]       i_pop_cnt,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid0,
    output logic             o_valid1,
    output fq_entry_t        o_head0,
    output fq_entry_t        o_head1
);

    fq_entry_t        r_mem [QDEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_head1;
    logic [PTR_W-1:0] w_tail1;
    logic [PTR_W-1:0] w_head_next;
    logic [PTR_W-1:0] w_tail_next;

    // Pointer advance modulo QDEPTH; QDEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(QDEPTH)) begin
            s = s - (PTR_W+1)'(QDEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        w_head1     = ptr_add(r_head, 2'd1);
        w_tail1     = ptr_add(r_tail, 2'd1);
        w_head_next = ptr_add(r_head, i_pop_cnt);
        w_tail_next = ptr_add(r_tail, i_push_cnt);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= r_count - CNT_W'(i_pop_cnt) + CNT_W'(i_push_cnt);
        end
    end

    // Entry storage; stale contents are masked by the valid gating below
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (i_push_cnt != 2'd0) begin
                r_mem[r_tail] <= i_push0;
            end
            if (i_push_cnt == 2'd2) begin
                r_mem[w_tail1] <= i_push1;
            end
        end
    end

    always_comb begin
        o_count  = r_count;
        o_valid0 = (r_count != '0);
        o_valid1 = (r_count >= CNT_W'(2));
        o_head0  = o_valid0 ? r_mem[r_head]  : '0;
        o_head1  = o_valid1 ? r_mem[w_head1] : '0;
    end

endmodule : fetch_queue

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC sequencing, dual-word fetch, redirect, issue queue.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         inst_fetch_unit_if.slave: memory port (inst_address,
//               instruction1/2), fetch_en, redirect_valid/pc, issue port
//               (issue_valid0/1, issue_inst0/1, issue_pc0/1, issue_take)
module inst_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int unsigned       QDEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_unit_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic [1:0]        w_take_req;
    logic [1:0]        w_take;
    logic [1:0]        w_push_cnt;
    logic [1:0]        w_pop_cnt;
    logic              w_flush;
    fq_entry_t         w_push0;
    fq_entry_t         w_push1;
    fq_entry_t         w_head0;
    fq_entry_t         w_head1;
    logic              w_unused;

    // Next-PC, enqueue count and effective take from the registered count
    always_comb begin
        w_pc_next  = r_pc;
        w_push_cnt = 2'd0;
        w_flush    = 1'b0;

        w_free     = CNT_W'(QDEPTH) - w_count;
        w_take_req = (bus.issue_take == 2'd3) ? 2'd2 : bus.issue_take;
        w_take     = (CNT_W'(w_take_req) > w_count) ? w_count[1:0] : w_take_req;

        if (bus.redirect_valid) begin
            w_flush   = 1'b1;
            w_pc_next = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (bus.fetch_en && (w_free != '0)) begin
            // Pair fetch only when two slots are free and the pair cannot wrap
            if ((w_free >= CNT_W'(2)) && (r_pc != LAST_WORD_ADDR)) begin
                w_push_cnt = 2'd2;
                w_pc_next  = r_pc + ADDR_W'(2 * INST_BYTES);
            end else begin
                w_push_cnt = 2'd1;
                w_pc_next  = r_pc + ADDR_W'(INST_BYTES);
            end
        end

        w_pop_cnt = w_flush ? 2'd0 : w_take;

        w_push0.inst = bus.instruction1;
        w_push0.pc   = r_pc;
        w_push1.inst = bus.instruction2;
        w_push1.pc   = r_pc + ADDR_W'(INST_BYTES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_flush),
        .i_push_cnt (w_push_cnt),
        .i_push0    (w_push0),
        .i_push1    (w_push1),
        .i_pop_cnt  (w_pop_cnt),
        .o_count    (w_count),
        .o_valid0   (bus.issue_valid0),
        .o_valid1   (bus.issue_valid1),
        .o_head0    (w_head0),
        .o_head1    (w_head1)
    );

    assign bus.inst_address = r_pc;
    assign bus.issue_inst0  = w_head0.inst;
    assign bus.issue_pc0    = w_head0.pc;
    assign bus.issue_inst1  = w_head1.inst;
    assign bus.issue_pc1    = w_head1.pc;

    // Redirect targets are forced word-aligned; the low bits are ignored
    assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit.
module tb_inst_fetch_unit;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .RESET_PC (8'h00),
        .QDEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: two real instructions at 0/4, address-tagged words elsewhere
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [7:0] wa;
        wa = {a[7:2], 2'b00};
        if (wa == 8'h00) return 32'h00500093;
        if (wa == 8'h04) return 32'hff200113;
        return {16'hC0DE, 8'h00, wa};
    endfunction

    always_comb begin
        bus.instruction1 = mem_word(bus.inst_address);
        bus.instruction2 = mem_word(bus.inst_address + 8'd4);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00; bus.issue_take = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.inst_address !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp %h", bus.inst_address, 8'h00); end
        checks++; if (bus.issue_valid0 !== 1'b0) begin errors++; $display("FAIL rst_v0 got %b exp 0", bus.issue_valid0); end
        checks++; if (bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL rst_v1 got %b exp 0", bus.issue_valid1); end
        checks++; if (bus.issue_inst0 !== 32'h0) begin errors++; $display("FAIL rst_inst0 got %h exp 0", bus.issue_inst0); end
        checks++; if (bus.issue_pc1 !== 8'h0) begin errors++; $display("FAIL rst_pc1 got %h exp 0", bus.issue_pc1); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1; bus.fetch_en = 1'b1;
        tick();
        checks++; if (bus.issue_valid0 !== 1'b1 || bus.issue_valid1 !== 1'b1) begin errors++; $display("FAIL ff_valid got %b%b exp 11", bus.issue_valid0, bus.issue_valid1); end
        checks++; if (bus.issue_inst0 !== 32'h00500093) begin errors++; $display("FAIL ff_inst0 got %h exp 00500093", bus.issue_inst0); end
        checks++; if (bus.issue_pc0 !== 8'h00) begin errors++; $display("FAIL ff_pc0 got %h exp 00", bus.issue_pc0); end
        checks++; if (bus.issue_inst1 !== 32'hff200113) begin errors++; $display("FAIL ff_inst1 got %h exp ff200113", bus.issue_inst1); end
        checks++; if (bus.issue_pc1 !== 8'h04) begin errors++; $display("FAIL ff_pc1 got %h exp 04", bus.issue_pc1); end
        checks++; if (bus.inst_address !== 8'h08) begin errors++; $display("FAIL ff_addr got %h exp 08", bus.inst_address); end
    endtask

    task automatic test_stall();
        bus.issue_take = 2'd0;
        tick();
        tick();
        checks++; if (bus.inst_address !== 8'h10) begin errors++; $display("FAIL stall_addr got %h exp 10", bus.inst_address); end
        checks++; if (bus.issue_pc0 !== 8'h00 || bus.issue_pc1 !== 8'h04) begin errors++; $display("FAIL stall_head got %h/%h exp 00/04", bus.issue_pc0, bus.issue_pc1); end
        // Drain two per cycle; every entry must appear once and in order
        bus.issue_take = 2'd2;
        for (int k = 1; k <= 3; k++) begin
            logic [7:0] epc;
            logic [7:0] eaddr;
            epc   = 8'(8 * k);
            eaddr = (k == 1) ? 8'h10 : 8'(8 * k + 8);
            tick();
            checks++; if (bus.issue_pc0 !== epc || bus.issue_pc1 !== epc + 8'd4) begin errors++; $display("FAIL drain%0d_pc got %h/%h exp %h/%h", k, bus.issue_pc0, bus.issue_pc1, epc, epc + 8'd4); end
            checks++; if (bus.issue_inst0 !== mem_word(epc) || bus.issue_inst1 !== mem_word(epc + 8'd4)) begin errors++; $display("FAIL drain%0d_inst got %h/%h exp %h/%h", k, bus.issue_inst0, bus.issue_inst1, mem_word(epc), mem_word(epc + 8'd4)); end
            checks++; if (bus.inst_address !== eaddr) begin errors++; $display("FAIL drain%0d_addr got %h exp %h", k, bus.inst_address, eaddr); end
        end
    endtask

    task automatic test_single_enqueue();
        bus.issue_take = 2'd1;
        tick();
        checks++; if (bus.issue_pc0 !== 8'h1C || bus.inst_address !== 8'h28) begin errors++; $display("FAIL se_setup got pc0 %h addr %h exp 1c 28", bus.issue_pc0, bus.inst_address); end
        bus.issue_take = 2'd0;
        tick();
        checks++; if (bus.inst_address !== 8'h2C) begin errors++; $display("FAIL se_addr got %h exp 2c", bus.inst_address); end
        tick();
        checks++; if (bus.inst_address !== 8'h2C) begin errors++; $display("FAIL se_full_addr got %h exp 2c", bus.inst_address); end
    endtask

    task automatic test_redirect();
        bus.fetch_en = 1'b0; bus.issue_take = 2'd1;
        tick();
        checks++; if (bus.issue_pc0 !== 8'h20) begin errors++; $display("FAIL rd_setup got %h exp 20", bus.issue_pc0); end
        bus.fetch_en = 1'b1; bus.issue_take = 2'd0; bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h2B;
        tick();
        checks++; if (bus.issue_valid0 !== 1'b0 || bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL rd_flush got %b%b exp 00", bus.issue_valid0, bus.issue_valid1); end
        checks++; if (bus.inst_address !== 8'h28) begin errors++; $display("FAIL rd_addr got %h exp 28", bus.inst_address); end
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.issue_pc0 !== 8'h28 || bus.issue_pc1 !== 8'h2C) begin errors++; $display("FAIL rd_head got %h/%h exp 28/2c", bus.issue_pc0, bus.issue_pc1); end
        checks++; if (bus.issue_inst0 !== mem_word(8'h28)) begin errors++; $display("FAIL rd_inst0 got %h exp %h", bus.issue_inst0, mem_word(8'h28)); end
        checks++; if (bus.inst_address !== 8'h30) begin errors++; $display("FAIL rd_next_addr got %h exp 30", bus.inst_address); end
    endtask

    task automatic test_take_clamp();
        bus.fetch_en = 1'b0; bus.issue_take = 2'd3;
        tick();
        checks++; if (bus.issue_valid0 !== 1'b0 || bus.inst_address !== 8'h30) begin errors++; $display("FAIL tc_take3 got v0 %b addr %h exp 0 30", bus.issue_valid0, bus.inst_address); end
        bus.fetch_en = 1'b1; bus.issue_take = 2'd2;
        tick();
        checks++; if (bus.issue_valid1 !== 1'b1 || bus.issue_pc0 !== 8'h30 || bus.issue_pc1 !== 8'h34) begin errors++; $display("FAIL tc_empty_take got v1 %b pc %h/%h exp 1 30/34", bus.issue_valid1, bus.issue_pc0, bus.issue_pc1); end
        bus.fetch_en = 1'b0; bus.issue_take = 2'd1;
        tick();
        checks++; if (bus.issue_valid0 !== 1'b1 || bus.issue_valid1 !== 1'b0 || bus.issue_pc0 !== 8'h34) begin errors++; $display("FAIL tc_take1 got v %b%b pc0 %h exp 10 34", bus.issue_valid0, bus.issue_valid1, bus.issue_pc0); end
    endtask

    task automatic test_wrap();
        bus.fetch_en = 1'b1; bus.issue_take = 2'd0; bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hFC;
        tick();
        checks++; if (bus.inst_address !== 8'hFC || bus.issue_valid0 !== 1'b0) begin errors++; $display("FAIL wr_setup got addr %h v0 %b exp fc 0", bus.inst_address, bus.issue_valid0); end
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.issue_valid0 !== 1'b1 || bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL wr_single got %b%b exp 10", bus.issue_valid0, bus.issue_valid1); end
        checks++; if (bus.issue_pc0 !== 8'hFC || bus.issue_inst0 !== 32'hC0DE00FC) begin errors++; $display("FAIL wr_entry got %h/%h exp fc/c0de00fc", bus.issue_pc0, bus.issue_inst0); end
        checks++; if (bus.inst_address !== 8'h00) begin errors++; $display("FAIL wr_addr got %h exp 00", bus.inst_address); end
        tick();
        checks++; if (bus.issue_pc1 !== 8'h00 || bus.issue_inst1 !== 32'h00500093) begin errors++; $display("FAIL wr_order got %h/%h exp 00/00500093", bus.issue_pc1, bus.issue_inst1); end
        checks++; if (bus.inst_address !== 8'h08) begin errors++; $display("FAIL wr_next_addr got %h exp 08", bus.inst_address); end
    endtask

    task automatic test_async_reset();
        tick();
        checks++; if (bus.inst_address !== 8'h0C || bus.issue_valid1 !== 1'b1) begin errors++; $display("FAIL ar_setup got addr %h v1 %b exp 0c 1", bus.inst_address, bus.issue_valid1); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.issue_valid0 !== 1'b0 || bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL ar_valid got %b%b exp 00", bus.issue_valid0, bus.issue_valid1); end
        checks++; if (bus.issue_inst0 !== 32'h0 || bus.issue_pc0 !== 8'h0 || bus.issue_inst1 !== 32'h0) begin errors++; $display("FAIL ar_data got %h/%h/%h exp 0/0/0", bus.issue_inst0, bus.issue_pc0, bus.issue_inst1); end
        checks++; if (bus.inst_address !== 8'h00) begin errors++; $display("FAIL ar_addr got %h exp 00", bus.inst_address); end
        #1 rst_n = 1'b1;
        tick();
        checks++; if (bus.issue_pc0 !== 8'h00 || bus.issue_inst0 !== 32'h00500093 || bus.issue_pc1 !== 8'h04) begin errors++; $display("FAIL ar_refetch got %h/%h/%h exp 00/00500093/04", bus.issue_pc0, bus.issue_inst0, bus.issue_pc1); end
        checks++; if (bus.inst_address !== 8'h08) begin errors++; $display("FAIL ar_next_addr got %h exp 08", bus.inst_address); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_single_enqueue();
        test_redirect();
        test_take_clamp();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_fetch_unit
